// File: rtl/io_pin_group_arbiter.sv
// Round-robin owner arbiter for one shared IO pin group. It inserts a tri-state
// turnaround window between owners and can optionally preempt an owner that holds the group too long.
module io_pin_group_arbiter #(
  parameter int unsigned REQ_COUNT         = 4,
  parameter int unsigned TURNAROUND_CYCLES = 4,
  parameter int unsigned HOLD_MAX          = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REQ_COUNT-1:0]         req,
  input  logic [REQ_COUNT-1:0]         req_mask,
  output logic [REQ_COUNT-1:0]         grant,
  output logic [$clog2(REQ_COUNT)-1:0] owner,
  output logic                         pin_safe,
  output logic                         busy,
  output logic [REQ_COUNT-1:0]         preempt
);

  localparam int unsigned OwW   = $clog2(REQ_COUNT);
  localparam int unsigned HoldW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam int unsigned TaW   = (TURNAROUND_CYCLES > 1) ? $clog2(TURNAROUND_CYCLES) : 1;

  localparam logic [OwW-1:0]       OwnerRst = OwW'(REQ_COUNT - 1);
  localparam logic [HoldW-1:0]     HoldSat  = HoldW'(HOLD_MAX);
  localparam logic [HoldW-1:0]     HoldLast = (HOLD_MAX > 0) ? HoldW'(HOLD_MAX - 1) : '0;
  localparam logic [TaW-1:0]       TaLoad   = TaW'(TURNAROUND_CYCLES - 1);
  localparam logic [REQ_COUNT-1:0] OneLsb   = {{(REQ_COUNT - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StGranted, StTurnaround} state_e;

  state_e               r_state, w_state_next;
  logic [REQ_COUNT-1:0] r_grant, w_grant_next;
  logic [OwW-1:0]       r_owner, w_owner_next;
  logic [HoldW-1:0]     r_hold, w_hold_next;
  logic [TaW-1:0]       r_ta_cnt, w_ta_cnt_next;
  logic                 r_pin_safe, w_pin_safe_next;
  logic                 r_busy, w_busy_next;
  logic [REQ_COUNT-1:0] r_preempt, w_preempt_next;

  logic [REQ_COUNT-1:0] w_elig;
  logic [REQ_COUNT-1:0] w_owner_oh;
  logic [REQ_COUNT-1:0] w_others;
  logic                 w_owner_elig;
  logic                 w_preempt_hit;
  logic [OwW-1:0]       w_sel;
  logic                 w_sel_valid;
  int unsigned          w_idx;

  always_comb begin
    w_elig        = req & req_mask;
    w_owner_oh    = OneLsb << r_owner;
    w_others      = w_elig & ~w_owner_oh;
    w_owner_elig  = |(w_elig & w_owner_oh);
    // The hold counter saturates at HOLD_MAX, so it passes HOLD_MAX-1 only once per grant.
    // That makes preemption a single-cycle window.
    w_preempt_hit = (HOLD_MAX != 0) && (r_hold == HoldLast) && (|w_others);
  end

  // Round-robin search that starts one past the last owner.
  always_comb begin
    w_sel       = '0;
    w_sel_valid = 1'b0;
    w_idx       = 0;
    for (int unsigned i = 1; i <= REQ_COUNT; i++) begin
      w_idx = 32'(r_owner) + i;
      if (w_idx >= REQ_COUNT) begin
        w_idx = w_idx - REQ_COUNT;
      end
      if (!w_sel_valid && w_elig[w_idx[OwW-1:0]]) begin
        w_sel_valid = 1'b1;
        w_sel       = w_idx[OwW-1:0];
      end
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_grant_next    = r_grant;
    w_owner_next    = r_owner;
    w_hold_next     = r_hold;
    w_ta_cnt_next   = r_ta_cnt;
    w_pin_safe_next = r_pin_safe;
    w_preempt_next  = '0;

    case (r_state)
      StIdle: begin
        w_grant_next    = '0;
        w_pin_safe_next = 1'b0;
        if (w_sel_valid) begin
          w_state_next = StGranted;
          w_grant_next = OneLsb << w_sel;
          w_owner_next = w_sel;
          w_hold_next  = '0;
        end
      end
      StGranted: begin
        if (!w_owner_elig || w_preempt_hit) begin
          w_state_next    = StTurnaround;
          w_grant_next    = '0;
          w_pin_safe_next = 1'b1;
          w_ta_cnt_next   = TaLoad;
          w_hold_next     = '0;
          // A voluntary release on the preemption cycle is not reported as preemption.
          if (w_owner_elig) begin
            w_preempt_next = w_owner_oh;
          end
        end else if (r_hold != HoldSat) begin
          w_hold_next = r_hold + 1'b1;
        end
      end
      StTurnaround: begin
        w_grant_next    = '0;
        w_pin_safe_next = 1'b1;
        if (r_ta_cnt == '0) begin
          w_state_next    = StIdle;
          w_pin_safe_next = 1'b0;
        end else begin
          w_ta_cnt_next = r_ta_cnt - 1'b1;
        end
      end
      default: begin
        w_state_next    = StIdle;
        w_grant_next    = '0;
        w_pin_safe_next = 1'b0;
      end
    endcase

    w_busy_next = (w_state_next != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_grant    <= '0;
      r_owner    <= OwnerRst;
      r_hold     <= '0;
      r_ta_cnt   <= '0;
      r_pin_safe <= 1'b0;
      r_busy     <= 1'b0;
      r_preempt  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_grant    <= w_grant_next;
      r_owner    <= w_owner_next;
      r_hold     <= w_hold_next;
      r_ta_cnt   <= w_ta_cnt_next;
      r_pin_safe <= w_pin_safe_next;
      r_busy     <= w_busy_next;
      r_preempt  <= w_preempt_next;
    end
  end

  assign grant    = r_grant;
  assign owner    = r_owner;
  assign pin_safe = r_pin_safe;
  assign busy     = r_busy;
  assign preempt  = r_preempt;

endmodule
